// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control for the single-cycle core; optional FETCH_BOUNDS_CHECK_EN faults on out-of-range fetch.
// A redirect lands on pc at the edge it is sampled (no delay slots); stall holds pc and the retire count.
// halt_req outranks stall, and HALT/FAULT drop fetch_valid.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          NUM_INST     = 128,
  parameter bit          ZERO_HALT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [32:0] PC_LIMIT = 33'(NUM_INST) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;

  logic        redirect;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        out_of_bounds;

  always_comb begin
    seq_pc        = pc_q + 32'd4;
    redirect      = jump | branch_taken;
    next_pc       = jump ? jump_target : (branch_taken ? branch_target : seq_pc);
    misaligned    = redirect && (next_pc[1:0] != 2'b00);
    out_of_bounds = BOUNDS_EN && ({1'b0, next_pc} >= PC_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (ZERO_HALT && (instruction == 32'h0)) begin
          state_d = S_HALT;
        end else if (!stall) begin
          // Alignment is checked before bounds so a bad redirect always reports as misaligned.
          if (misaligned) begin
            state_d = S_FAULT;
            cause_d = 2'b01;
          end else if (out_of_bounds) begin
            state_d = S_FAULT;
            cause_d = 2'b10;
          end else begin
            pc_d  = next_pc;
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_HALT: begin
        if (resume && !halt_req) state_d = S_RUN;
      end
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 32'h0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign fetch_valid = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = cause_q;
  assign inst_count  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: per-cycle comparison against an abstract model plus hand-computed checkpoints.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam int          NI  = 128;
  localparam logic [31:0] NOP = 32'h0000_0293;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic [31:0] zero_pc = 32'hFFFF_FFF0;
  logic [31:0] instruction;
  logic [31:0] pc, pc_plus4, inst_count;
  logic        fetch_valid, halted, fault;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Program image: every word is an ordinary instruction except the one at zero_pc.
  assign instruction = (pc == zero_pc) ? 32'h0 : NOP;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_VECTOR(RV), .NUM_INST(NI), .ZERO_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted),
    .fault(fault), .fault_cause(fault_cause), .inst_count(inst_count)
  );

  // Abstract model: mode 0 booting, 1 running, 2 halted, 3 faulted.
  int          m_mode  = 0;
  logic [31:0] m_pc    = RV;
  logic [31:0] m_cnt   = 32'h0;
  logic [1:0]  m_cause = 2'b00;
  logic [31:0] m_word, m_next;
  bit          m_redir, m_oob;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = RV; m_cnt = 0; m_cause = 2'b00;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_word  = (m_pc == zero_pc) ? 32'h0 : NOP;
      m_redir = jump || branch_taken;
      m_next  = jump ? jump_target : (branch_taken ? branch_target : m_pc + 32'd4);
`ifdef FETCH_BOUNDS_CHECK_EN
      m_oob = longint'(m_next) >= longint'(NI) * 4;
`else
      m_oob = 1'b0;
`endif
      if (halt_req || m_word == 32'h0) m_mode = 2;
      else if (!stall) begin
        if (m_redir && (m_next % 4) != 0) begin m_mode = 3; m_cause = 2'b01; end
        else if (m_oob) begin m_mode = 3; m_cause = 2'b10; end
        else begin m_pc = m_next; m_cnt = m_cnt + 1; end
      end
    end else if (m_mode == 2) begin
      if (resume && !halt_req) m_mode = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_mode == 1});
      chk("m_halted", {31'b0, halted}, {31'b0, m_mode == 2});
      chk("m_fault", {31'b0, fault}, {31'b0, m_mode == 3});
      chk("m_cause", {30'b0, fault_cause}, {30'b0, m_cause});
      chk("m_count", inst_count, m_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_cycle();
    #1 rst_n = 1'b0;
    step(1);
    #1 rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_cause", {30'b0, fault_cause}, 32'h0);
    chk("rst_count", inst_count, 32'h0);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;
    chk("boot_fv", {31'b0, fetch_valid}, 32'h0);

    // Sequential fetch then a simultaneous jump and branch
    step(1); chk("seq_pc0", pc, 32'h0); chk("seq_fv", {31'b0, fetch_valid}, 32'h1);
    step(1); chk("seq_pc4", pc, 32'h4);
    step(1); chk("seq_pc8", pc, 32'h8); chk("seq_cnt2", inst_count, 32'd2);
    jump = 1; jump_target = 32'h20; branch_taken = 1; branch_target = 32'h40;
    step(1); chk("jmp_wins", pc, 32'h20); chk("cnt3", inst_count, 32'd3);
    jump = 0; branch_taken = 0; stall = 1;
    step(3); chk("stall_pc", pc, 32'h20); chk("stall_cnt", inst_count, 32'd3);
    stall = 0;

    // Zero word halts; resume continues at the held pc
    jump = 1; jump_target = 32'hC;
    step(1); chk("to_c", pc, 32'hC); jump = 0; zero_pc = 32'hC;
    step(1); chk("zh_halted", {31'b0, halted}, 32'h1); chk("zh_pc", pc, 32'hC);
    chk("zh_cnt", inst_count, 32'd4);
    step(1); chk("zh_hold", {31'b0, halted}, 32'h1);
    zero_pc = 32'hFFFF_FFF0; resume = 1;
    step(1); chk("res_fv", {31'b0, fetch_valid}, 32'h1); resume = 0;
    step(1); chk("res_pc", pc, 32'h10); chk("res_cnt", inst_count, 32'd5);

    // halt_req beats stall; resume is ignored while halt_req stays high
    halt_req = 1; stall = 1;
    step(1); chk("hreq_halted", {31'b0, halted}, 32'h1); stall = 0; resume = 1;
    step(1); chk("hreq_hold", {31'b0, halted}, 32'h1); halt_req = 0;
    step(1); chk("hreq_res", {31'b0, fetch_valid}, 32'h1); resume = 0;

    // Resuming onto a zero word re-halts on the next edge
    zero_pc = 32'h10;
    step(1); chk("rh_h1", {31'b0, halted}, 32'h1); resume = 1;
    step(1); chk("rh_run", {31'b0, fetch_valid}, 32'h1); resume = 0;
    step(1); chk("rh_h2", {31'b0, halted}, 32'h1);
    zero_pc = 32'hFFFF_FFF0; resume = 1;
    step(1); resume = 0; chk("rh_pc", pc, 32'h10);

    // PC wrap at the top of the address space
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(1); jump = 0;
`ifndef FETCH_BOUNDS_CHECK_EN
    chk("wrap_pc", pc, 32'hFFFF_FFFC); chk("wrap_p4", pc_plus4, 32'h0);
    step(1); chk("wrap_to0", pc, 32'h0);
`else
    chk("wrap_cause", {30'b0, fault_cause}, 32'h2);
    step(1);
`endif
    reset_cycle();

    // Last word of the image, then one past it
    jump = 1; jump_target = 32'h1FC;
    step(1); jump = 0;
    step(1);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_cause", {30'b0, fault_cause}, 32'h2); chk("oob_pc", pc, 32'h1FC);
`else
    chk("nob_pc", pc, 32'h200);
`endif
    reset_cycle();

    // Misaligned redirect: ignored under stall, faults otherwise
    stall = 1; jump = 1; jump_target = 32'h22;
    step(1); chk("mis_stall", {31'b0, fault}, 32'h0); stall = 0;
    step(1); chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_cause", {30'b0, fault_cause}, 32'h1); chk("mis_pc", pc, 32'h0);
    jump = 0; resume = 1; halt_req = 1;
    step(2); chk("mis_sticky", {31'b0, fault}, 32'h1); chk("mis_nohalt", {31'b0, halted}, 32'h0);
    resume = 0; halt_req = 0;
    #1 rst_n = 1'b0;
    #1 chk("mis_clr", {31'b0, fault}, 32'h0); chk("mis_clr_cause", {30'b0, fault_cause}, 32'h0);
    step(1); #1 rst_n = 1'b1;
    step(1);

    // Asynchronous reset between clock edges
    jump = 1; jump_target = 32'h24;
    step(1); jump = 0; chk("pre_pc", pc, 32'h24); chk("pre_cnt", inst_count, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst_pc", pc, RV); chk("arst_cnt", inst_count, 32'h0);
    chk("arst_fv", {31'b0, fetch_valid}, 32'h0);
    step(1); #1 rst_n = 1'b1;
    step(2); chk("post_pc", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory in the single-cycle RISC-V core.
- Holds the architectural PC and drives it to the memory, which is indexed by pc>>2.
- Selects the next PC from sequential, branch or jump targets, and supports stalls.
- Halts when an all-zero instruction word (end of program image) or a halt request is seen; faults on misaligned redirects.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- NUM_INST, 128: instruction-memory depth in words; used by the optional bounds check.
- ZERO_HALT, 1: when 1, a fetched instruction of 32'h0 while RUN forces HALT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instruction  input  32  word returned by the instruction memory for the current pc.
- stall  input  1  hold PC and counters this cycle.
- branch_taken  input  1  conditional branch resolved taken.
- branch_target  input  32  branch destination.
- jump  input  1  unconditional jump (JAL/JALR).
- jump_target  input  32  jump destination.
- halt_req  input  1  external halt request.
- resume  input  1  leave HALT and continue at the held pc.
- pc  output  32  current fetch address, to the instruction memory.
- pc_plus4  output  32  pc + 4 (combinational), for link writeback.
- fetch_valid  output  1  instruction at pc is to be executed this cycle.
- halted  output  1  state is HALT.
- fault  output  1  state is FAULT (sticky).
- fault_cause  output  2  2'b00 none, 2'b01 misaligned target, 2'b10 out of bounds.
- inst_count  output  32  retired-instruction counter.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - pc=RESET_VECTOR, state=BOOT, inst_count=0, fault_cause=0.
  - Outputs: fetch_valid=0, halted=0, fault=0.
  - Asserting reset mid-operation, in any state, returns immediately to these values.
- States: BOOT, RUN, HALT, FAULT. State is registered; fetch_valid, halted and fault decode from state only.
- BOOT: lasts exactly one clock edge after rst_n deasserts; pc holds; moves to RUN. The first valid fetch is therefore cycle 1 after reset release.
- RUN: fetch_valid=1. At each edge, evaluate in priority order:
  1. halt_req=1 -> HALT, pc holds, inst_count holds. This has priority over stall.
  2. ZERO_HALT && instruction==32'h0 -> HALT, pc holds, not counted.
  3. stall=1 -> pc and inst_count hold. Redirect inputs are ignored; upstream re-presents them.
  4. Otherwise:
     - next = jump ? jump_target : branch_taken ? branch_target : pc+4. Jump wins when jump and branch_taken are both set.
     - If a selected redirect target has bits[1:0]!=0 -> FAULT, fault_cause=2'b01, pc holds, not counted.
     - Else pc<=next and inst_count<=inst_count+1 (wraps 2^32-1 -> 0).
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC advances to 32'h0 (without the bounds check).
- HALT: fetch_valid=0, halted=1, pc holds.
  - resume=1 and halt_req=0 -> RUN at the next edge.
  - Resume with the zero-word still at pc re-halts on the following edge.
- FAULT: fetch_valid=0, fault=1, fault_cause held, pc holds. Exit only via rst_n.
- Latency: redirect takes effect on pc at the edge it is sampled; there are no delay slots.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In RUN, a non-stalled advance whose next >= NUM_INST*4 goes to FAULT with fault_cause=2'b10; pc holds, not counted.
  - This check has lower priority than the misaligned check.
- Undefined:
  - No bounds logic; fault_cause never takes 2'b10.
  - pc advances freely and wraps modulo 2^32.

Test Plan:
- Reset then release, instruction=32'h0000_0293 constant, no redirects -> cycle0 BOOT fetch_valid=0; pc sequence 0,4,8,12 from cycle1; inst_count=3 after 3 advancing edges.
- At pc=8, assert branch_taken=1, branch_target=32'h40 together with jump=1, jump_target=32'h20 -> pc=32'h20 next; then stall=1 for 3 cycles -> pc stays 32'h20, inst_count unchanged.
- Run to pc=12 where instruction=32'h0 -> halted=1, fetch_valid=0, pc=12; halt_req=0 with resume=1 while the word is nonzero -> RUN, pc advances to 16.
- jump=1, jump_target=32'h0000_0022 -> fault=1, fault_cause=2'b01, pc unchanged; resume and halt_req ignored; rst_n low clears to pc=0, fault=0.
- With FETCH_BOUNDS_CHECK_EN and NUM_INST=4 -> advancing from pc=12 gives FAULT, cause 2'b10, pc=12. Without the macro -> pc=16.
- Assert rst_n low mid-RUN at pc=32'h24 between clock edges -> pc=RESET_VECTOR and inst_count=0 immediately, without waiting for a clock edge.
